// File: rtl/misaligned_memory_handler_if.sv
// Pipeline-side request/response handshake plus the word-organised data memory port.
interface misaligned_memory_handler_if #(
   parameter int ADDR_W = 12
);
   logic              req;
   logic              we;
   logic [2:0]        rw_type;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              ready;
   logic              done;
   logic              err;
   logic [31:0]       rdata;
   logic [ADDR_W-3:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_we;
   logic [31:0]       mem_rdata;

   modport master (
      output req, we, rw_type, addr, wdata,
      input  ready, done, err, rdata
   );

   modport slave (
      input  req, we, rw_type, addr, wdata, mem_rdata,
      output ready, done, err, rdata, mem_addr, mem_wdata, mem_we
   );

   modport memory (
      input  mem_addr, mem_wdata, mem_we,
      output mem_rdata
   );
endinterface

// File: rtl/misaligned_memory_handler.sv
// Sequenced load/store unit: splits misaligned half/word accesses into two memory beats.
// Latency 2..3+2*RD_LAT cycles to done; ready is low (pipeline stalled) while an access is in flight.
module misaligned_memory_handler #(
   parameter int ADDR_W           = 12,
   parameter int RD_LAT           = 1,
   parameter int ALLOW_MISALIGNED = 1
) (
   input logic                   clk,
   input logic                   rst_n,
   misaligned_memory_handler_if.slave bus
);
   localparam int AW = ADDR_W - 2;

   localparam logic [2:0] RW_BYTE   = 3'd0;
   localparam logic [2:0] RW_HALF   = 3'd1;
   localparam logic [2:0] RW_WORD   = 3'd2;
   localparam logic [2:0] RW_BYTE_U = 3'd4;
   localparam logic [2:0] RW_HALF_U = 3'd5;

   typedef enum logic [2:0] {S_IDLE, S_B0, S_W0, S_B1, S_W1, S_RESP} state_t;

   state_t         state, state_n;
   logic [1:0]     wcnt;
   logic [1:0]     off_q;
   logic [2:0]     type_q;
   logic           we_q;
   logic           split_q;
   logic           err_q;
   logic [AW-1:0]  word0_q;
   logic [7:0]     mask_q;
   logic [63:0]    lane_q;
   logic [31:0]    lo_q;
   logic [31:0]    rdata_q;
   logic [AW-1:0]  mem_addr_q;

   logic [1:0]     in_off;
   logic [2:0]     in_size;
   logic           in_type_ok;
   logic           in_misaligned;
   logic           in_illegal;
   logic           in_split;
   logic [7:0]     in_mask;
   logic [63:0]    in_lane;
   logic           last_wait;
   logic [63:0]    ld_cat;
   logic [31:0]    ld_sh;
   logic [31:0]    ld_ext;

   // Decode of the request as presented; only used on the acceptance edge.
   always_comb begin
      in_off     = bus.addr[1:0];
      in_size    = 3'd1;
      in_type_ok = 1'b1;
      case (bus.rw_type)
         RW_BYTE, RW_BYTE_U: in_size = 3'd1;
         RW_HALF, RW_HALF_U: in_size = 3'd2;
         RW_WORD:            in_size = 3'd4;
         default:            in_type_ok = 1'b0;
      endcase
      in_misaligned = ((in_size == 3'd2) && in_off[0]) || ((in_size == 3'd4) && (in_off != 2'd0));
      in_illegal    = !in_type_ok
                    || (bus.we && ((bus.rw_type == RW_BYTE_U) || (bus.rw_type == RW_HALF_U)))
                    || ((ALLOW_MISALIGNED == 0) && in_misaligned);
      in_split      = ({1'b0, in_off} + in_size) > 3'd4;
      in_mask       = ((8'd1 << in_size) - 8'd1) << in_off;
      in_lane       = {32'h0, bus.wdata} << {in_off, 3'b000};
   end

   assign last_wait = (wcnt == 2'(RD_LAT - 1));

   // The second word is still arriving on mem_rdata when W1 ends, so assemble from the live bus.
   always_comb begin
      ld_cat = (state == S_W1) ? {bus.mem_rdata, lo_q} : {32'h0, bus.mem_rdata};
      ld_sh  = 32'(ld_cat >> {off_q, 3'b000});
      case (type_q)
         RW_BYTE:   ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
         RW_BYTE_U: ld_ext = {24'h0, ld_sh[7:0]};
         RW_HALF:   ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
         RW_HALF_U: ld_ext = {16'h0, ld_sh[15:0]};
         default:   ld_ext = ld_sh;
      endcase
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: if (bus.req) state_n = in_illegal ? S_RESP : S_B0;
         S_B0: begin
            if (!we_q)        state_n = S_W0;
            else if (split_q) state_n = S_B1;
            else              state_n = S_RESP;
         end
         S_W0:   if (last_wait) state_n = split_q ? S_B1 : S_RESP;
         S_B1:   state_n = we_q ? S_RESP : S_W1;
         S_W1:   if (last_wait) state_n = S_RESP;
         S_RESP: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         wcnt       <= 2'd0;
         off_q      <= 2'd0;
         type_q     <= 3'd0;
         we_q       <= 1'b0;
         split_q    <= 1'b0;
         err_q      <= 1'b0;
         word0_q    <= '0;
         mask_q     <= 8'h0;
         lane_q     <= 64'h0;
         lo_q       <= 32'h0;
         rdata_q    <= 32'h0;
         mem_addr_q <= '0;
      end else begin
         state <= state_n;
         if ((state_n == S_B1) && (state != S_B1))
            mem_addr_q <= word0_q + AW'(1);
         case (state)
            S_IDLE: begin
               if (bus.req) begin
                  off_q   <= in_off;
                  type_q  <= bus.rw_type;
                  we_q    <= bus.we;
                  split_q <= in_split;
                  err_q   <= in_illegal;
                  word0_q <= bus.addr[ADDR_W-1:2];
                  mask_q  <= in_mask;
                  lane_q  <= in_lane;
                  wcnt    <= 2'd0;
                  if (in_illegal) rdata_q    <= 32'h0;
                  else            mem_addr_q <= bus.addr[ADDR_W-1:2];
               end
            end
            S_W0: begin
               if (last_wait) begin
                  wcnt <= 2'd0;
                  lo_q <= bus.mem_rdata;
                  if (!split_q) rdata_q <= ld_ext;
               end else begin
                  wcnt <= wcnt + 2'd1;
               end
            end
            S_W1: begin
               if (last_wait) begin
                  wcnt    <= 2'd0;
                  rdata_q <= ld_ext;
               end else begin
                  wcnt <= wcnt + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Write strobes decode straight from state so reset removes them without waiting for a clock.
   always_comb begin
      bus.mem_we    = 4'h0;
      bus.mem_wdata = 32'h0;
      if (we_q && (state == S_B0)) begin
         bus.mem_we    = mask_q[3:0];
         bus.mem_wdata = lane_q[31:0];
      end else if (we_q && (state == S_B1)) begin
         bus.mem_we    = mask_q[7:4];
         bus.mem_wdata = lane_q[63:32];
      end
   end

   assign bus.ready    = (state == S_IDLE);
   assign bus.done     = (state == S_RESP);
   assign bus.err      = (state == S_RESP) && err_q;
   assign bus.rdata    = rdata_q;
   assign bus.mem_addr = mem_addr_q;
endmodule

// File: tb/tb_misaligned_memory_handler.sv
// Directed bench: three handler instances (RD_LAT=1, RD_LAT=3, misaligned rejected) share one memory model.
module tb_misaligned_memory_handler;
   localparam logic [2:0] BYTE = 3'd0, HALF = 3'd1, WORD = 3'd2, BYTE_U = 3'd4, HALF_U = 3'd5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        preload = 1'b0;
   logic [2:0]  req_v = 3'b000;
   logic        we = 1'b0;
   logic [2:0]  rw_type = 3'd0;
   logic [11:0] addr = 12'h0;
   logic [31:0] wdata = 32'h0;

   logic        o_ready [3];
   logic        o_done [3];
   logic        o_err [3];
   logic [31:0] o_rdata [3];
   logic [9:0]  o_mem_addr [3];
   logic [31:0] o_mem_wdata [3];
   logic [3:0]  o_mem_we [3];

   logic [31:0] mem [0:1023];
   logic [31:0] rdp [3][3];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   for (genvar i = 0; i < 3; i++) begin : g
      localparam int LAT = (i == 1) ? 3 : 1;
      localparam int AM  = (i == 2) ? 0 : 1;
      misaligned_memory_handler_if #(.ADDR_W(12)) bus ();
      misaligned_memory_handler #(.ADDR_W(12), .RD_LAT(LAT), .ALLOW_MISALIGNED(AM)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
      assign bus.req       = req_v[i];
      assign bus.we        = we;
      assign bus.rw_type   = rw_type;
      assign bus.addr      = addr;
      assign bus.wdata     = wdata;
      assign bus.mem_rdata = rdp[i][LAT-1];
      assign o_ready[i]     = bus.ready;
      assign o_done[i]      = bus.done;
      assign o_err[i]       = bus.err;
      assign o_rdata[i]     = bus.rdata;
      assign o_mem_addr[i]  = bus.mem_addr;
      assign o_mem_wdata[i] = bus.mem_wdata;
      assign o_mem_we[i]    = bus.mem_we;
   end

   always @(posedge clk) begin
      if (preload) begin
         mem[0]     <= 32'h44332211;
         mem[1]     <= 32'h88776655;
         mem[3]     <= 32'h0;
         mem[4]     <= 32'h0;
         mem[1023]  <= 32'hA1B2C3D4;
      end
      for (int i = 0; i < 3; i++) begin
         for (int b = 0; b < 4; b++)
            if (o_mem_we[i][b]) mem[o_mem_addr[i]][8*b +: 8] <= o_mem_wdata[i][8*b +: 8];
         rdp[i][0] <= mem[o_mem_addr[i]];
         rdp[i][1] <= rdp[i][0];
         rdp[i][2] <= rdp[i][1];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   int          done_cyc;
   logic        got_err;
   logic [31:0] got_rdata;
   logic        rdy0, rdy1;
   logic [9:0]  cyc_addr [20];
   logic [3:0]  cyc_we [20];
   logic [31:0] cyc_wdata [20];

   // One access on instance inst; inputs are scrambled right after acceptance.
   task automatic run(input int inst, input logic w, input logic [2:0] t,
                      input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      rdy0     = o_ready[inst];
      we       = w;
      rw_type  = t;
      addr     = a;
      wdata    = d;
      req_v[inst] = 1'b1;
      @(posedge clk);
      #1;
      req_v    = 3'b000;
      we       = ~w;
      rw_type  = WORD;
      addr     = a ^ 12'hFFF;
      wdata    = ~d;
      done_cyc = -1;
      got_err  = 1'b0;
      got_rdata = 32'h0;
      for (int k = 1; k < 20 && done_cyc < 0; k++) begin
         @(negedge clk);
         if (k == 1) rdy1 = o_ready[inst];
         cyc_addr[k]  = o_mem_addr[inst];
         cyc_we[k]    = o_mem_we[inst];
         cyc_wdata[k] = o_mem_wdata[inst];
         if (o_done[inst]) begin
            done_cyc  = k;
            got_err   = o_err[inst];
            got_rdata = o_rdata[inst];
         end
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      preload = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(o_ready[0]), 32'd1);
      chk("rst_done", 32'(o_done[0]), 32'd0);
      chk("rst_err", 32'(o_err[0]), 32'd0);
      chk("rst_rdata", o_rdata[0], 32'h0);
      chk("rst_mem_addr", 32'(o_mem_addr[0]), 32'h0);
      chk("rst_mem_we", 32'(o_mem_we[0]), 32'h0);
      chk("rst_mem_wdata", o_mem_wdata[0], 32'h0);
      preload = 1'b0;
      rst_n   = 1'b1;

      run(0, 1'b0, BYTE, 12'h007, 32'h0);
      chk("lb7_rdy0", 32'(rdy0), 32'd1);
      chk("lb7_rdy1", 32'(rdy1), 32'd0);
      chk("lb7_done", 32'(done_cyc), 32'd3);
      chk("lb7_err", 32'(got_err), 32'd0);
      chk("lb7_rdata", got_rdata, 32'hFFFFFF88);
      chk("lb7_addr", 32'(cyc_addr[1]), 32'd1);
      chk("lb7_we", 32'(cyc_we[1]), 32'd0);

      run(0, 1'b0, WORD, 12'h001, 32'h0);
      chk("lw1_b2b_rdy", 32'(rdy0), 32'd1);
      chk("lw1_done", 32'(done_cyc), 32'd5);
      chk("lw1_addr0", 32'(cyc_addr[1]), 32'd0);
      chk("lw1_addr1", 32'(cyc_addr[3]), 32'd1);
      chk("lw1_rdata", got_rdata, 32'h55443322);

      run(1, 1'b0, WORD, 12'h001, 32'h0);
      chk("lw1_lat3_done", 32'(done_cyc), 32'd9);
      chk("lw1_lat3_addr1", 32'(cyc_addr[5]), 32'd1);
      chk("lw1_lat3_rdata", got_rdata, 32'h55443322);

      run(0, 1'b0, HALF_U, 12'hFFF, 32'h0);
      chk("lhu_wrap_addr0", 32'(cyc_addr[1]), 32'h3FF);
      chk("lhu_wrap_addr1", 32'(cyc_addr[3]), 32'h000);
      chk("lhu_wrap_done", 32'(done_cyc), 32'd5);
      chk("lhu_wrap_rdata", got_rdata, 32'h000011A1);

      run(0, 1'b0, HALF, 12'h006, 32'h0);
      chk("lh6_done", 32'(done_cyc), 32'd3);
      chk("lh6_rdata", got_rdata, 32'hFFFF8877);

      run(2, 1'b0, WORD, 12'h002, 32'h0);
      chk("am0_lw2_done", 32'(done_cyc), 32'd1);
      chk("am0_lw2_err", 32'(got_err), 32'd1);
      chk("am0_lw2_rdata", got_rdata, 32'h0);
      chk("am0_lw2_we", 32'(cyc_we[1]), 32'd0);

      run(2, 1'b1, BYTE_U, 12'h005, 32'h12345678);
      chk("am0_sbu_done", 32'(done_cyc), 32'd1);
      chk("am0_sbu_err", 32'(got_err), 32'd1);
      chk("am0_sbu_we", 32'(cyc_we[1]), 32'd0);

      run(2, 1'b0, WORD, 12'h004, 32'h0);
      chk("am0_lw4_done", 32'(done_cyc), 32'd3);
      chk("am0_lw4_err", 32'(got_err), 32'd0);
      chk("am0_lw4_rdata", got_rdata, 32'h88776655);

      run(0, 1'b0, 3'd7, 12'h000, 32'h0);
      chk("badtype_done", 32'(done_cyc), 32'd1);
      chk("badtype_err", 32'(got_err), 32'd1);

      // Split word store interrupted by reset during its second beat.
      @(negedge clk);
      we = 1'b1; rw_type = WORD; addr = 12'h00E; wdata = 32'hCAFEF00D;
      req_v[0] = 1'b1;
      @(posedge clk);
      #1;
      req_v = 3'b000;
      wdata = 32'h0;
      @(negedge clk);
      chk("rst_sw_b0_addr", 32'(o_mem_addr[0]), 32'd3);
      chk("rst_sw_b0_we", 32'(o_mem_we[0]), 32'b1100);
      chk("rst_sw_b0_wdata", o_mem_wdata[0], 32'hF00D0000);
      @(negedge clk);
      chk("rst_sw_b1_addr", 32'(o_mem_addr[0]), 32'd4);
      chk("rst_sw_b1_we", 32'(o_mem_we[0]), 32'b0011);
      chk("rst_sw_b1_wdata", o_mem_wdata[0], 32'h0000CAFE);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_we", 32'(o_mem_we[0]), 32'h0);
      chk("rst_mid_ready", 32'(o_ready[0]), 32'd1);
      chk("rst_mid_done", 32'(o_done[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_mem3", mem[3], 32'hF00D0000);
      chk("rst_mem4", mem[4], 32'h0);
      run(0, 1'b0, WORD, 12'h004, 32'h0);
      chk("post_rst_lw4_rdata", got_rdata, 32'h88776655);
      chk("post_rst_lw4_done", 32'(done_cyc), 32'd3);

      run(0, 1'b1, HALF, 12'h003, 32'h0000BEEF);
      chk("sh3_b0_addr", 32'(cyc_addr[1]), 32'd0);
      chk("sh3_b0_we", 32'(cyc_we[1]), 32'b1000);
      chk("sh3_b0_byte", 32'(cyc_wdata[1][31:24]), 32'hEF);
      chk("sh3_b1_addr", 32'(cyc_addr[2]), 32'd1);
      chk("sh3_b1_we", 32'(cyc_we[2]), 32'b0001);
      chk("sh3_b1_byte", 32'(cyc_wdata[2][7:0]), 32'hBE);
      chk("sh3_done", 32'(done_cyc), 32'd3);
      chk("sh3_err", 32'(got_err), 32'd0);
      chk("sh3_resp_we", 32'(cyc_we[3]), 32'd0);
      chk("sh3_mem0", mem[0], 32'hEF332211);
      chk("sh3_mem1", mem[1], 32'h887766BE);

      run(0, 1'b0, WORD, 12'h000, 32'h0);
      chk("lw0_after_sh", got_rdata, 32'hEF332211);

      run(0, 1'b1, BYTE_U, 12'h001, 32'h0);
      chk("sbu_err", 32'(got_err), 32'd1);
      chk("sbu_rdata", got_rdata, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/misaligned_memory_handler.md
# misaligned_memory_handler

Sequenced load/store unit between the pipeline MEM stage and the word-organised synchronous data memory. It adds three things to combinational byte/half/word handling: misaligned half and word accesses split into two memory beats, configurable memory read latency, and a req/ready/done handshake that stalls the pipeline while an access is in flight. Sign and zero extension and byte-lane write enables are produced as before, using the codebase RWType encoding (BYTE, BYTE_U, HALF, HALF_U, WORD).

## Interface
- ADDR_W, 12, byte-address width; the memory word index is ADDR_W-2 bits.
- RD_LAT, 1, memory read latency in cycles from the address cycle to mem_rdata valid; legal values are 1 to 3.
- ALLOW_MISALIGNED, 1, selects behaviour for misaligned half/word accesses: 1 splits them into two beats, 0 rejects them with err.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  access request; sampled only when ready=1.
- we  in  1  1 = store, 0 = load.
- rw_type  in  3  access type in RWType encoding.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-aligned.
- ready  out  1  high only in IDLE. Reset value 1.
- done  out  1  one-cycle completion pulse. Reset value 0.
- err  out  1  valid with done; set for an illegal type or a rejected misaligned access. Reset value 0.
- rdata  out  32  extended load result; held stable from done until the next done. Reset value 0.
- mem_addr  out  ADDR_W-2  word index. Reset value 0.
- mem_wdata  out  32  lane-positioned store data. Reset value 0.
- mem_we  out  4  byte write enables. Reset value 0.
- mem_rdata  in  32  memory read data.

## Operation
- An access is accepted on a rising edge where req=1 and ready=1. addr, rw_type, we and wdata are latched at acceptance; changes to these inputs afterwards have no effect on the access.
- Address and size terms:
  - off = addr[1:0].
  - size = 1 for BYTE/BYTE_U, 2 for HALF/HALF_U, 4 for WORD.
  - split = (off + size > 4).
  - word0 = addr[ADDR_W-1:2].
  - word1 = word0 + 1, wrapping modulo 2^(ADDR_W-2).
- Illegal accesses:
  - A store with BYTE_U or HALF_U, or any undefined rw_type, goes straight to RESP with err=1 and rdata=0. It performs no memory beat.
  - With ALLOW_MISALIGNED=0, a HALF/HALF_U/WORD access with an off that is not a multiple of its size gets the same err handling.
- States: IDLE -> B0 -> (W0 on loads) -> [B1 -> (W1 on loads)] -> RESP -> IDLE. The B1/W1 pair is entered only when split=1.
- B0 and B1 are single cycles. mem_addr is word0 in B0 and word1 in B1.
- Stores:
  - The byte mask is ((1<<size)-1) << off, 8 bits wide.
  - The data lane is wdata << (8*off), 64 bits wide.
  - B0 drives mem_we = mask[3:0] and mem_wdata = lane[31:0].
  - B1 drives mem_we = mask[7:4] and mem_wdata = lane[63:32].
  - After the last beat the FSM goes to RESP.
- Loads:
  - The W0/W1 state lasts RD_LAT cycles. During it mem_addr is held and mem_we=0.
  - mem_rdata is captured on the last W edge: into lo for W0, hi for W1.
  - The result is ({hi,lo} >> 8*off), truncated to size bytes, then sign-extended (BYTE, HALF) or zero-extended (BYTE_U, HALF_U, WORD). For a non-split access hi is don't-care.
  - rdata is updated on entry to RESP.
- RESP: done=1 for one cycle, then the FSM returns to IDLE with ready=1 in the following cycle.
- Outside B0/B1, mem_we=0 and mem_wdata=0. mem_addr keeps its last value.
- Asserting rst_n low in any state immediately forces IDLE and all outputs to their reset values; mem_we goes to 0 asynchronously. A partially completed split store is not rolled back.

## Timing
- Cycles are counted from the acceptance edge (cycle 0). done is high in the cycle shown.
- Aligned store: done in cycle 2.
- Split store: done in cycle 3.
- Aligned load: done in cycle 2 + RD_LAT.
- Split load: done in cycle 3 + 2*RD_LAT.
- err access: done in cycle 1.
- ready is low from cycle 1 through the done cycle. req is ignored while ready=0.
- Back-to-back: the earliest next acceptance is the edge at the end of the cycle after done.

## Test plan
Preload mem[0]=0x44332211 and mem[1]=0x88776655. Use RD_LAT=1 unless stated.
- LB at addr 0x007 -> rdata=0xFFFFFF88, err=0, done in cycle 3, one memory beat with mem_addr=1.
- LW at addr 0x001 -> mem_addr=0 then 1, rdata=0x55443322, done in cycle 5. Repeat with RD_LAT=3 -> done in cycle 9.
- SH at addr 0x003, wdata=0x0000BEEF -> B0: mem_addr=0, mem_we=1000, mem_wdata[31:24]=0xEF. B1: mem_addr=1, mem_we=0001, mem_wdata[7:0]=0xBE. Memory ends as mem[0]=0xEF332211, mem[1]=0x887766BE; done in cycle 3.
- ALLOW_MISALIGNED=0, LW at addr 0x002 -> err=1, rdata=0, mem_we stays 0, done in cycle 1. SB with rw_type=BYTE_U -> same result.
- ADDR_W=12, LHU at addr 0xFFF -> mem_addr=0x3FF then 0x000 (wrap), rdata = zero-extended {mem[0][7:0], mem[0x3FF][31:24]}.
- Split store: drop rst_n during B1 -> mem_we=0 immediately, ready=1, done=0. After reset is released, LW at 0x004 -> 0x88776655.
